// File: rtl/cpu_bus_responder_pkg.sv
// cpu_bus_defs: region/DMA enums, address map constants and the CPU address decoder shared with the IE.
package cpu_bus_defs;
  typedef enum logic [2:0] {REG_RAM, REG_PPU, REG_DMA, REG_UNMAPPED, REG_CART} region_e;
  typedef enum logic [1:0] {DMA_IDLE, DMA_RD, DMA_WR} dma_state_e;
  localparam logic [15:0] PPU_BASE     = 16'h2000;
  localparam logic [15:0] IO_BASE      = 16'h4000;
  localparam logic [15:0] OAM_DMA_ADDR = 16'h4014;
  localparam logic [15:0] CART_BASE    = 16'h8000;
  localparam logic [2:0]  OAMDATA_SEL  = 3'd4;
  function automatic region_e decode(input logic [15:0] a);
    return a >= CART_BASE ? REG_CART :
           a == OAM_DMA_ADDR ? REG_DMA :
           a < PPU_BASE ? REG_RAM :
           a < IO_BASE ? REG_PPU : REG_UNMAPPED;
  endfunction
endpackage

// File: rtl/cpu_work_ram.sv
// cpu_work_ram: single-port work RAM, registered write-first read.
module cpu_work_ram #(
  parameter int RAM_ADDR_W = 11
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [RAM_ADDR_W-1:0] addr_i,
  input  logic [7:0]            wdata_i,
  output logic [7:0]            rdata_o
);
  logic [7:0] mem [2**RAM_ADDR_W];
  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wdata_i;
    rdata_o <= we_i ? wdata_i : mem[addr_i];
  end
endmodule

// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: CPU bus decode to work RAM, PPU window and cart; OAM DMA engine built when OAM_DMA_EN is defined.
module cpu_bus_responder
  import cpu_bus_defs::*;
#(
  parameter int RAM_ADDR_W = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bus_addr,
  input  logic [7:0]  bus_wdata,
  input  logic        bus_write_en,
  output logic [7:0]  bus_rdata,
  output logic        dma_busy,
  output logic [2:0]  ppu_reg_sel,
  output logic [7:0]  ppu_wdata,
  output logic        ppu_wr,
  output logic        ppu_rd,
  input  logic [7:0]  ppu_rdata,
  output logic [14:0] prg_addr,
  input  logic [7:0]  prg_rdata,
  output logic        prg_wr
);
  region_e     rgn;
  logic        busy, dma_ppu_wr, cpu_wr, ram_we, ppu_acc, rd_new;
  logic [14:0] dma_addr, mem_addr;
  logic [7:0]  dma_byte, ram_rdata, rdata_q, ppu_wdata_q;
  logic        src_ram_q, rd_vld_q, ppu_wr_q, ppu_rd_q, prg_wr_q;
  logic [2:0]  sel_q;
  logic [15:0] rd_addr_q;

  assign rgn      = decode(bus_addr);
  assign cpu_wr   = bus_write_en & ~busy;
  assign ram_we   = cpu_wr & (rgn == REG_RAM);
  assign ppu_acc  = ~busy & (rgn == REG_PPU);
  assign rd_new   = ~rd_vld_q | (bus_addr != rd_addr_q);
  assign mem_addr = busy ? dma_addr : bus_addr[14:0];
  assign prg_addr = rst ? mem_addr : '0;

  cpu_work_ram #(.RAM_ADDR_W(RAM_ADDR_W)) u_ram (
    .clk    (clk),
    .we_i   (ram_we),
    .addr_i (mem_addr[RAM_ADDR_W-1:0]),
    .wdata_i(bus_wdata),
    .rdata_o(ram_rdata)
  );

`ifdef OAM_DMA_EN
  dma_state_e state_q;
  logic [7:0] page_q, cnt_q;
  logic       busy_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= DMA_IDLE;
      page_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        DMA_IDLE: if (bus_write_en && bus_addr == OAM_DMA_ADDR) begin
          page_q  <= bus_wdata;
          state_q <= DMA_RD;
          busy_q  <= 1'b1;
        end
        DMA_RD: state_q <= DMA_WR;
        default: begin
          cnt_q   <= cnt_q + 8'd1;
          state_q <= cnt_q == 8'hFF ? DMA_IDLE : DMA_RD;
          busy_q  <= cnt_q != 8'hFF;
        end
      endcase
    end
  end
  assign busy       = busy_q;
  assign dma_addr   = {page_q[6:0], cnt_q};
  assign dma_ppu_wr = state_q == DMA_WR;
  // RAM byte arrives one cycle after DMA_RD addresses it; cart data is combinational
  assign dma_byte   = page_q < 8'h20 ? ram_rdata : page_q[7] ? prg_rdata : 8'h00;
`else
  assign busy       = 1'b0;
  assign dma_addr   = '0;
  assign dma_ppu_wr = 1'b0;
  assign dma_byte   = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      src_ram_q   <= 1'b0;
      rdata_q     <= '0;
      rd_vld_q    <= 1'b0;
      rd_addr_q   <= '0;
      ppu_rd_q    <= 1'b0;
      ppu_wr_q    <= 1'b0;
      prg_wr_q    <= 1'b0;
      sel_q       <= '0;
      ppu_wdata_q <= '0;
    end else begin
      src_ram_q   <= ~busy & (rgn == REG_RAM);
      rdata_q     <= busy ? bus_rdata : rgn == REG_PPU ? ppu_rdata : rgn == REG_CART ? prg_rdata : bus_rdata;
      rd_vld_q    <= ppu_acc & ~bus_write_en;
      rd_addr_q   <= bus_addr;
      ppu_rd_q    <= ppu_acc & ~bus_write_en & rd_new;
      ppu_wr_q    <= dma_ppu_wr | (ppu_acc & bus_write_en);
      prg_wr_q    <= cpu_wr & (rgn == REG_CART);
      sel_q       <= dma_ppu_wr ? OAMDATA_SEL : ppu_acc ? bus_addr[2:0] : sel_q;
      ppu_wdata_q <= dma_ppu_wr ? dma_byte : (ppu_acc & bus_write_en) ? bus_wdata : ppu_wdata_q;
    end
  end

  assign bus_rdata   = src_ram_q ? ram_rdata : rdata_q;
  assign dma_busy    = busy;
  assign ppu_reg_sel = sel_q;
  assign ppu_wdata   = ppu_wdata_q;
  assign ppu_wr      = ppu_wr_q;
  assign ppu_rd      = ppu_rd_q;
  assign prg_wr      = prg_wr_q;
endmodule

// File: tb/tb_cpu_bus_responder.sv
// tb_cpu_bus_responder: directed self-checking bench for cpu_bus_responder (DMA steps follow OAM_DMA_EN).
module tb_cpu_bus_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_write_en;
  logic [7:0]  bus_rdata;
  logic        dma_busy;
  logic [2:0]  ppu_reg_sel;
  logic [7:0]  ppu_wdata;
  logic        ppu_wr;
  logic        ppu_rd;
  logic [7:0]  ppu_rdata;
  logic [14:0] prg_addr;
  logic [7:0]  prg_rdata;
  logic        prg_wr;
  int n_cmp = 0;
  int n_bad = 0;

  cpu_bus_responder dut (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_write_en(bus_write_en), .bus_rdata(bus_rdata), .dma_busy(dma_busy),
    .ppu_reg_sel(ppu_reg_sel), .ppu_wdata(ppu_wdata), .ppu_wr(ppu_wr), .ppu_rd(ppu_rd),
    .ppu_rdata(ppu_rdata), .prg_addr(prg_addr), .prg_rdata(prg_rdata), .prg_wr(prg_wr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic we, input logic [7:0] d);
    bus_addr = a;
    bus_write_en = we;
    bus_wdata = d;
  endtask

  initial begin
    int rd_n, wr_n, busy_n, err_n, rd_err, hold_err;
    rst = 1'b0;
    drive(16'h8005, 1'b0, 8'h00);
    ppu_rdata = 8'hA5;
    prg_rdata = 8'hC3;
    tick();
    tick();
    chk("rst_rdata", bus_rdata, 0);
    chk("rst_busy", dma_busy, 0);
    chk("rst_ppu_wr", ppu_wr, 0);
    chk("rst_ppu_rd", ppu_rd, 0);
    chk("rst_prg_wr", prg_wr, 0);
    chk("rst_sel", ppu_reg_sel, 0);
    chk("rst_wdata", ppu_wdata, 0);
    chk("rst_prg_addr", prg_addr, 0);
    rst = 1'b1;
    // RAM write then mirrored read
    drive(16'h0800, 1'b1, 8'h11);
    tick();
    drive(16'h0123, 1'b1, 8'h5A);
    tick();
    drive(16'h1923, 1'b0, 8'h00);
    tick();
    chk("ram_mirror_rd", bus_rdata, 8'h5A);
    chk("ram_no_ppu_wr", ppu_wr, 0);
    // held PPU read strobes once
    drive(16'h2002, 1'b0, 8'h00);
    rd_n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      rd_n += int'(ppu_rd);
    end
    chk("ppu_rd_once", rd_n, 1);
    chk("ppu_rd_sel", ppu_reg_sel, 2);
    chk("ppu_rdata", bus_rdata, 8'hA5);
    drive(16'h3FFA, 1'b0, 8'h00);
    tick();
    chk("ppu_rd_mirror", ppu_rd, 1);
    chk("ppu_rd_mirror_sel", ppu_reg_sel, 2);
    tick();
    chk("ppu_rd_drop", ppu_rd, 0);
    // PPU write
    drive(16'h2005, 1'b1, 8'h77);
    tick();
    chk("ppu_wr", ppu_wr, 1);
    chk("ppu_wr_sel", ppu_reg_sel, 5);
    chk("ppu_wr_data", ppu_wdata, 8'h77);
    chk("ppu_wr_no_rd", ppu_rd, 0);
    drive(16'h0123, 1'b0, 8'h00);
    tick();
    chk("ppu_wr_single", ppu_wr, 0);
    chk("ram_rd_5a", bus_rdata, 8'h5A);
    // unmapped write
    drive(16'h4000, 1'b1, 8'hEE);
    tick();
    chk("unm_hold", bus_rdata, 8'h5A);
    chk("unm_ppu_wr", ppu_wr, 0);
    chk("unm_prg_wr", prg_wr, 0);
    drive(16'h0000, 1'b0, 8'h00);
    tick();
    chk("unm_ram_keep", bus_rdata, 8'h11);
    // cart
    drive(16'h8003, 1'b0, 8'h00);
    tick();
    chk("cart_addr", prg_addr, 15'h0003);
    chk("cart_rdata", bus_rdata, 8'hC3);
    drive(16'hFFFF, 1'b1, 8'h01);
    tick();
    chk("prg_wr", prg_wr, 1);
    chk("prg_wr_no_ppu", ppu_wr, 0);
    drive(16'h8003, 1'b0, 8'h00);
    tick();
    chk("prg_wr_single", prg_wr, 0);
`ifdef OAM_DMA_EN
    for (int i = 0; i < 256; i++) begin
      drive(16'h0200 + 16'(i), 1'b1, 8'(i));
      tick();
    end
    drive(16'h0123, 1'b0, 8'h00);
    tick();
    drive(16'h4014, 1'b1, 8'h02);
    tick();
    chk("dma_start", dma_busy, 1);
    chk("dma_start_hold", bus_rdata, 8'h5A);
    busy_n = 1;
    wr_n = 0;
    err_n = 0;
    rd_err = 0;
    hold_err = 0;
    for (int k = 0; k < 520; k++) begin
      if (k < 100) drive(16'h0000, 1'b1, 8'hFF);
      else if (k < 200) drive(16'h4014, 1'b1, 8'h80);
      else if (k < 300) drive(16'h2002, 1'b0, 8'h00);
      else drive(16'h0123, 1'b0, 8'h00);
      tick();
      busy_n += int'(dma_busy);
      if (ppu_wr) begin
        if (ppu_wdata !== 8'(wr_n) || ppu_reg_sel !== 3'd4) err_n++;
        wr_n++;
      end
      rd_err += int'(ppu_rd);
      if (bus_rdata !== 8'h5A) hold_err++;
    end
    chk("dma_busy_cycles", busy_n, 512);
    chk("dma_wr_count", wr_n, 256);
    chk("dma_data_errs", err_n, 0);
    chk("dma_ppu_rd", rd_err, 0);
    chk("dma_rdata_hold", hold_err, 0);
    chk("dma_done", dma_busy, 0);
    drive(16'h0000, 1'b0, 8'h00);
    tick();
    chk("dma_cpu_wr_drop", bus_rdata, 8'h11);
    // reset mid-transfer
    drive(16'h4014, 1'b1, 8'h02);
    tick();
    drive(16'h0123, 1'b0, 8'h00);
    wr_n = 0;
    for (int k = 0; k < 300 && wr_n < 100; k++) begin
      tick();
      wr_n += int'(ppu_wr);
    end
    chk("abort_reached", wr_n, 100);
    rst = 1'b0;
    tick();
    chk("abort_ppu_wr", ppu_wr, 0);
    chk("abort_busy", dma_busy, 0);
    chk("abort_rdata", bus_rdata, 0);
    chk("abort_sel", ppu_reg_sel, 0);
    chk("abort_wdata", ppu_wdata, 0);
    chk("abort_prg_addr", prg_addr, 0);
    chk("abort_ppu_rd", ppu_rd, 0);
    chk("abort_prg_wr", prg_wr, 0);
    rst = 1'b1;
    wr_n = 0;
    busy_n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      wr_n += int'(ppu_wr);
      busy_n += int'(dma_busy);
    end
    chk("abort_no_resume_wr", wr_n, 0);
    chk("abort_no_resume_busy", busy_n, 0);
`else
    drive(16'h0123, 1'b0, 8'h00);
    tick();
    drive(16'h4014, 1'b1, 8'h02);
    tick();
    chk("nodma_hold", bus_rdata, 8'h5A);
    drive(16'h0123, 1'b0, 8'h00);
    wr_n = 0;
    busy_n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      wr_n += int'(ppu_wr);
      busy_n += int'(dma_busy);
    end
    chk("nodma_busy", busy_n, 0);
    chk("nodma_ppu_wr", wr_n, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cpu_bus_responder.md
# cpu_bus_responder

Responder end of the CPU memory bus driven by the instruction-execute FSM. Decodes each CPU address into 2 KB internal work RAM (mirrored), the PPU register window (mirrored every 8 bytes), the OAM DMA trigger at $4014, and cartridge PRG space. Returns read data with one-cycle registered latency and forwards writes as single-cycle strobes. When OAM DMA is compiled in, it runs a 256-byte copy into PPU OAMDATA and stalls the CPU for the duration.

## Interface
- RAM_ADDR_W, 11, work RAM address width (2 KB); mirror mask = low RAM_ADDR_W bits of $0000-$1FFF
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- bus_addr  in  16  CPU address
- bus_wdata  in  8  CPU write data
- bus_write_en  in  1  CPU write strobe; a write commits on every cycle it is high
- bus_rdata  out  8  registered read data
- dma_busy  out  1  OAM DMA in progress; CPU must hold off
- ppu_reg_sel  out  3  PPU register index (bus_addr[2:0] or 4 during DMA)
- ppu_wdata  out  8  PPU write data
- ppu_wr  out  1  one-cycle PPU write strobe
- ppu_rd  out  1  one-cycle PPU read strobe (side-effect reads)
- ppu_rdata  in  8  PPU register read data, valid the cycle ppu_rd is high
- prg_addr  out  15  cartridge address ($8000-$FFFF, bit 15 dropped)
- prg_rdata  in  8  cartridge data, combinational from prg_addr
- prg_wr  out  1  one-cycle mapper write strobe ($8000-$FFFF)

## Operation
- Decode: $0000-$1FFF RAM; $2000-$3FFF PPU; $4014 DMA trigger; $4000-$4013 and $4015-$7FFF unmapped; $8000-$FFFF cart.
- Reads: on each edge, sample bus_addr and load bus_rdata with the selected source. Sources: RAM word at bus_addr[10:0]; ppu_rdata; prg_rdata. Unmapped reads hold the previous bus_rdata (open bus).
- PPU reads: assert ppu_rd for exactly one cycle when bus_addr first enters the PPU window or changes within it. Holding an address never repeats the strobe, so a $2002 read clears vblank once.
- Writes: when bus_write_en is high, commit one write per cycle. RAM stores bus_wdata. PPU window pulses ppu_wr with ppu_reg_sel=bus_addr[2:0]. Cart pulses prg_wr. Unmapped writes are dropped.
- FSM states:
  - IDLE: a write to $4014 latches page P = bus_wdata and goes to DMA_RD.
  - DMA_RD: internally addresses {P, cnt}; goes to DMA_WR.
  - DMA_WR: pulses ppu_wr with sel=4 and the fetched byte; increments cnt. Returns to IDLE when cnt wraps $FF→$00, otherwise goes to DMA_RD.
- DMA sources: pages $00-$1F read RAM (mirrored); pages $80-$FF read cart; all other pages transfer $00.
- While dma_busy is high: CPU writes are ignored, ppu_rd is suppressed, and bus_rdata holds its value.

## Timing
- Reset values: bus_rdata=0, dma_busy=0, ppu_wr=0, ppu_rd=0, prg_wr=0, ppu_reg_sel=0, ppu_wdata=0, prg_addr=0, state=IDLE, cnt=0. RAM contents are not reset.
- Read latency is 1 cycle. An address presented before edge N gives valid bus_rdata after edge N, held while the address is stable. This matches the IE's two-cycle load wait.
- Write strobes (ppu_wr, prg_wr) are registered: high for the one cycle after the edge that sampled bus_write_en. A RAM write is visible to a read of the same address issued on the next cycle.
- DMA timing:
  - dma_busy rises on the edge that samples the $4014 write.
  - 256 bytes take 512 cycles (one DMA_RD plus one DMA_WR per byte).
  - dma_busy falls on the edge after the final DMA_WR.
  - A $4014 write during DMA is ignored.
- Reset asserted mid-DMA aborts the transfer at the next edge. No further ppu_wr is issued.
- A simultaneous ppu_rd/ppu_wr is impossible: a write cycle suppresses ppu_rd.

## Configuration
- OAM_DMA_EN defined: DMA FSM, page register, counter and dma_busy logic are built.
- OAM_DMA_EN undefined: $4014 decodes as unmapped (write dropped), dma_busy is tied 0, and the FSM is absent.

## Structure
- Package cpu_bus_defs, shared with the IE:
  - region enum (REG_RAM, REG_PPU, REG_DMA, REG_UNMAPPED, REG_CART)
  - address constants (PPU_BASE=$2000, OAM_DMA_ADDR=$4014, CART_BASE=$8000, OAMDATA_SEL=3'd4)
  - DMA state enum
- Sub-module cpu_work_ram: synchronous single-port RAM of 2**RAM_ADDR_W bytes, registered read, write-first. The responder muxes CPU and DMA addresses into it.

## Test plan
- Write $5A to $0123, read $1923 (mirror) -> bus_rdata=$5A one cycle after address.
- Hold bus_addr=$2002 for 4 cycles -> ppu_rd high exactly once, ppu_reg_sel=2; then read $3FFA -> second ppu_rd pulse, sel=2.
- Write $77 to $2005 -> single ppu_wr, sel=5, ppu_wdata=$77; write to $4000 -> no strobe, RAM and bus_rdata unchanged.
- RAM $0200-$02FF preloaded with i; write $02 to $4014:
  - dma_busy high for 512 cycles
  - 256 ppu_wr pulses, sel=4, data $00..$FF in order
  - CPU write to $0000 during DMA dropped
- Pull rst low at DMA byte 100 -> ppu_wr stops next edge, dma_busy=0, all outputs at reset values.
- Read $8003 with prg_rdata=$C3 -> prg_addr=$0003, bus_rdata=$C3; write $01 to $FFFF -> prg_wr one cycle.
